// File: rtl/xnor_gate.sv
// Bitwise XNOR/equality cell with registered copies and an optional saturating match counter.
// Define XNOR_GATE_STATS_EN to build match_cnt; otherwise it is tied to zero and cnt_clr is ignored.
module xnor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] y_q,
    output logic             eq,
    output logic             eq_q,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] match_cnt
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign Y[gi] = ~(A[gi] ^ B[gi]);
        end
    endgenerate

    assign eq = &Y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q  <= '0;
            eq_q <= 1'b0;
        end else begin
            y_q  <= Y;
            eq_q <= eq;
        end
    end

`ifdef XNOR_GATE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority over a simultaneous match; the count saturates rather than wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (eq && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_xnor_gate.sv
// Directed bench for xnor_gate: a WIDTH=1 instance and a WIDTH=4/CNT_W=4 instance.
// Counter expectations follow XNOR_GATE_STATS_EN at compile time.
module tb_xnor_gate;

`ifdef XNOR_GATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       cnt_clr;
    logic       a1, b1;
    logic       y1, y1_q, eq1, eq1_q;
    logic [7:0] cnt1;
    logic [3:0] a4, b4;
    logic [3:0] y4, y4_q;
    logic       eq4, eq4_q;
    logic [3:0] cnt4;

    int checks_total  = 0;
    int checks_passed = 0;

    xnor_gate #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Y(y1), .y_q(y1_q),
        .eq(eq1), .eq_q(eq1_q), .cnt_clr(cnt_clr), .match_cnt(cnt1)
    );

    xnor_gate #(.WIDTH(4), .CNT_W(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Y(y4), .y_q(y4_q),
        .eq(eq4), .eq_q(eq4_q), .cnt_clr(cnt_clr), .match_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
            $display("check %s: got %0h ok", tag, obs);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [1:0] t1_ab [4];
    logic       t1_y  [4];
    int         cnt_exp;

    initial begin
        t1_ab = '{2'b00, 2'b01, 2'b10, 2'b11};
        t1_y  = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst_n   = 1'b0;
        cnt_clr = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        a4 = 4'b0000; b4 = 4'b0000;
        #2;
        check("rst_y1_q",  y1_q,  0);
        check("rst_eq1_q", eq1_q, 0);
        check("rst_cnt1",  cnt1,  0);
        check("rst_y4_q",  y4_q,  0);
        check("rst_eq4_q", eq4_q, 0);
        check("rst_cnt4",  cnt4,  0);

        // T1: combinational truth table, WIDTH=1
        for (int i = 0; i < 4; i++) begin
            a1 = t1_ab[i][1];
            b1 = t1_ab[i][0];
            #10;
            check($sformatf("t1_y_%0d", i),  y1,  t1_y[i]);
            check($sformatf("t1_eq_%0d", i), eq1, t1_y[i]);
        end

        // T2: WIDTH=4 combinational
        a4 = 4'b1010; b4 = 4'b1001; #1;
        check("t2_y_ne",  y4,  4'b1100);
        check("t2_eq_ne", eq4, 0);
        b4 = 4'b1010; #1;
        check("t2_y_eq",  y4,  4'b1111);
        check("t2_eq_eq", eq4, 1);

        // Release reset with the 4-bit operands unequal so the counter stays idle
        @(negedge clk);
        b4 = 4'b0101;
        a1 = 1'b1; b1 = 1'b1;
        rst_n = 1'b1;

        // T3: one-cycle latency
        @(posedge clk); #1;
        check("t3_y_q_1",  y1_q,  1);
        check("t3_eq_q_1", eq1_q, 1);
        check("t3_y4_q",   y4_q,  4'b0000);
        @(negedge clk);
        b1 = 1'b0; #1;
        check("t3_y_now",  y1,   0);
        check("t3_y_q_hold", y1_q, 1);
        @(posedge clk); #1;
        check("t3_y_q_0",  y1_q,  0);
        check("t3_eq_q_0", eq1_q, 0);
        check("t3_cnt4_idle", cnt4, 0);

        // T4: five matching edges, then asynchronous reset between edges
        @(negedge clk);
        b4 = a4;
        for (int i = 0; i < 5; i++) @(posedge clk);
        @(negedge clk);
        check("t4_y4_q",  y4_q,  4'b1111);
        check("t4_eq4_q", eq4_q, 1);
        check("t4_cnt4",  cnt4,  STATS ? 5 : 0);
        #2;
        rst_n = 1'b0; #1;
        check("t4_rst_y4_q",  y4_q,  0);
        check("t4_rst_eq4_q", eq4_q, 0);
        check("t4_rst_cnt4",  cnt4,  0);
        check("t4_rst_y4",    y4,    4'b1111);
        check("t4_rst_eq4",   eq4,   1);
        @(posedge clk); #1;
        check("t4_hold_y4_q", y4_q, 0);
        check("t4_hold_cnt4", cnt4, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // T5/T6: saturation with eq held high
        cnt_exp = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (STATS && cnt_exp < 15) cnt_exp++;
            check($sformatf("t5_cnt4_%0d", i), cnt4, cnt_exp);
        end
        check("t5_cnt1", cnt1, STATS ? 0 : 0);
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        check("t5_clr", cnt4, 0);
        @(negedge clk);
        cnt_clr = 1'b0;
        @(posedge clk); #1;
        check("t5_after_clr", cnt4, STATS ? 1 : 0);
        @(negedge clk);
        b4 = 4'b0000;
        @(posedge clk); #1;
        check("t5_hold_ne", cnt4, STATS ? 1 : 0);
        check("t5_eq4_q_ne", eq4_q, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
